// File: rtl/seq_muldiv_32.sv
// Iterative 32-bit unsigned multiply / restoring divide driving the shared ALU adder.
// Division datapath is built only when SEQ_MULDIV_DIV_EN is defined; otherwise op=1 returns err.
module seq_muldiv_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err,
    output logic [31:0] as_x,
    output logic [31:0] as_y,
    output logic        as_sub,
    input  logic [31:0] as_s
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;   // P for MUL, R for DIV
    logic [31:0] q_q, q_d;
    logic [31:0] m_q, m_d;       // M for MUL, D for DIV
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        err_q, err_d;
    logic        carry;
`ifdef SEQ_MULDIV_DIV_EN
    logic        op_q, op_d;
`endif

    // Adder carry-out rebuilt from operand and sum MSBs.
    assign carry = (as_x[31] & (as_y[31] ^ as_sub))
                 | ((as_x[31] | (as_y[31] ^ as_sub)) & ~as_s[31]);

    always_comb begin
        as_x   = '0;
        as_y   = '0;
        as_sub = 1'b0;
        if (state_q == S_RUN) begin
            as_x = acc_q;
            as_y = m_q;
`ifdef SEQ_MULDIV_DIV_EN
            if (op_q) begin
                as_x   = {acc_q[30:0], q_q[31]};
                as_sub = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
`ifdef SEQ_MULDIV_DIV_EN
        op_d    = op_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    acc_d = '0;
`ifdef SEQ_MULDIV_DIV_EN
                    op_d = op;
                    if (op) begin
                        q_d = a;
                        m_d = b;
                        if (b == '0) begin
                            state_d = S_DONE;
                            hi_d    = a;
                            lo_d    = '1;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        q_d     = b;
                        m_d     = a;
                        state_d = S_RUN;
                    end
`else
                    if (op) begin
                        state_d = S_DONE;
                        hi_d    = '0;
                        lo_d    = '0;
                        err_d   = 1'b1;
                    end else begin
                        q_d     = b;
                        m_d     = a;
                        state_d = S_RUN;
                    end
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 5'd1;
`ifdef SEQ_MULDIV_DIV_EN
                if (op_q) begin
                    // Shifted remainder with bit 32 set always exceeds D.
                    if (acc_q[31] | carry) begin
                        acc_d = as_s;
                        q_d   = {q_q[30:0], 1'b1};
                    end else begin
                        acc_d = as_x;
                        q_d   = {q_q[30:0], 1'b0};
                    end
                end else
`endif
                if (q_q[0]) begin
                    {acc_d, q_d} = {carry, as_s, q_q[31:1]};
                end else begin
                    {acc_d, q_d} = {1'b0, acc_q, q_q[31:1]};
                end
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    hi_d    = acc_d;
                    lo_d    = q_d;
                    err_d   = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
`ifdef SEQ_MULDIV_DIV_EN
            op_q    <= op_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign err  = err_q;

endmodule

// File: tb/tb_seq_muldiv_32.sv
// Scoreboard bench for seq_muldiv_32: issued requests push expected results, a monitor checks done pulses.
module tb_seq_muldiv_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, err, as_sub;
    logic [31:0] hi, lo, as_x, as_y, as_s;

`ifdef SEQ_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    seq_muldiv_32 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .err(err),
        .as_x(as_x), .as_y(as_y), .as_sub(as_sub), .as_s(as_s)
    );

    always #5 clk = ~clk;

    // The ALU adder the unit borrows.
    assign as_s = as_sub ? (as_x - as_y) : (as_x + as_y);

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          next_free = 0;
    int          acc_last = -1000;
    int          span_last = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y, input int acc);
        exp_t        e;
        logic [63:0] p;
        e.acc = acc;
        e.err = 1'b0;
        e.lat = 32;
        if (!o) begin
            p    = {32'd0, x} * {32'd0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (!DIV_EN) begin
            e.hi = '0; e.lo = '0; e.err = 1'b1; e.lat = 0;
        end else if (y == 0) begin
            e.hi = x; e.lo = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = 0;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
        end
        return e;
    endfunction

    // Called at a negedge while start is driven and the model says the unit is idle.
    task automatic accept(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e = model(o, x, y, edges + 1);
        sb.push_back(e);
        acc_last  = e.acc;
        span_last = e.lat + 1;
        next_free = e.acc + e.lat + 2;
    endtask

    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        while (edges + 1 < next_free) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        accept(o, x, y);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: busy window, adder idle, done results with latency, result hold.
    always begin
        exp_t e;
        logic run_exp;
        @(posedge clk);
        #1;
        if (rst_n) begin
            chk("busy", {63'd0, busy}, {63'd0, (edges >= acc_last && edges < acc_last + span_last)});
            run_exp = (span_last == 33) && (edges >= acc_last) && (edges < acc_last + 32);
            if (!run_exp) begin
                chk("adder_idle", {as_x, as_y}, 64'd0);
                chk("adder_sub_idle", {63'd0, as_sub}, 64'd0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("hi", {32'd0, hi}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo}, {32'd0, e.lo});
                    chk("err", {63'd0, err}, {63'd0, e.err});
                    chk("latency", 64'(edges - e.acc), 64'(e.lat));
                    last_hi  = e.hi;
                    last_lo  = e.lo;
                    last_err = e.err;
                end
            end else begin
                chk("hold_hilo", {hi, lo}, {last_hi, last_lo});
                chk("hold_err", {63'd0, err}, {63'd0, last_err});
                if (sb.size() > 0 && edges > sb[0].acc + sb[0].lat) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_timeout: got no done expected done at edge %0d", sb[0].acc + sb[0].lat);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {60'd0, busy, done, err, as_sub}, 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, 64'd0);
        chk({tag, "_adder"}, {as_x, as_y}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        o;
        logic [31:0] x, y;

        #2;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        next_free = edges + 1;

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(1'b1, 32'd100, 32'd7, 1);
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        issue(1'b1, 32'd1234, 32'd0, 2);
        issue(1'b0, 32'h0001_0000, 32'h0001_0000, 0);

        // Second start during RUN must be ignored.
        issue(1'b0, 32'd3, 32'd5, 0);
        while (edges < acc_last + 9) @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        issue(1'b0, 32'd2, 32'd11, 0);

        // Reset in the middle of a MUL.
        issue(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        while (edges != acc_last + 15) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_hi = '0; last_lo = '0; last_err = 1'b0;
        acc_last = -1000; span_last = 0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        next_free = edges + 1;
        issue(1'b0, 32'd6, 32'd7, 0);

        // start held high: one accept per IDLE visit.
        @(negedge clk);
        while (edges + 1 < next_free) @(negedge clk);
        start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
        accept(1'b0, a, b);
        @(negedge clk);
        while (edges + 1 < next_free) @(negedge clk);
        accept(1'b0, a, b);
        @(negedge clk);
        start = 1'b0;

        @(negedge clk);
        while (edges + 1 < next_free) @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd77; b = 32'd0;
        accept(1'b1, a, b);
        @(negedge clk);
        while (edges + 1 < next_free) @(negedge clk);
        accept(1'b1, a, b);
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            issue(o, x, y, $urandom_range(0, 3));
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
